// File: rtl/serial_tx_framer.sv
// serial_tx_framer: buffers 16-bit words and sends them to a UART transmitter as SYNC/LEN/payload frames.
// Define SERIAL_TX_FRAMER_CHECKSUM_EN to append an XOR checksum byte (CSUM) to every frame.
module serial_tx_framer #(
   parameter int         FRAME_WORDS = 4,
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] SYNC_BYTE   = 8'hAA
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Word_DV,
   input  logic [15:0] i_Word,
   output logic        o_Word_Ready,
   output logic        o_Tx_DV,
   output logic [7:0]  o_Tx_Byte,
   input  logic        i_Tx_Active,
   input  logic        i_Tx_Done,
   output logic        o_Frame_Done,
   output logic        o_Overflow
);

   localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW        = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] FRAME_C   = CW'(FRAME_WORDS);
   localparam logic [7:0]    LEN_BYTE  = 8'(FRAME_WORDS * 2);
   localparam logic [5:0]    LAST_WORD = 6'(FRAME_WORDS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      LEN     = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
      , CSUM  = 3'd5
`endif
   } state_t;

   logic [15:0]   fifo_mem_r [2**AW];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [CW-1:0] count_r, count_next_s;
   logic          ready_r, overflow_r;
   logic          push_s, pop_s, advance_s;
   logic [15:0]   rd_word_s;

   state_t        state_r, state_next_s;
   logic          tx_dv_r, tx_dv_next_s;
   logic [7:0]    tx_byte_r, tx_byte_next_s;
   logic [7:0]    lo_byte_r, lo_byte_next_s;
   logic [5:0]    word_cnt_r, word_cnt_next_s;
   logic          frame_done_r, frame_done_next_s;
   logic          tx_done_prev_r;

`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
   logic [7:0]    csum_r, csum_next_s;

   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   assign push_s    = i_Word_DV && ready_r;
   assign rd_word_s = fifo_mem_r[rd_ptr_r];
   // Only a fresh rising edge of Done, after the byte was accepted, moves the frame on
   assign advance_s = !tx_dv_r && i_Tx_Done && !tx_done_prev_r;

   // FIFO occupancy after this cycle's push and pop
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Frame sequencer: byte selection, DV handshake and FIFO pop
   always_comb begin
      state_next_s      = state_r;
      tx_byte_next_s    = tx_byte_r;
      lo_byte_next_s    = lo_byte_r;
      word_cnt_next_s   = word_cnt_r;
      frame_done_next_s = 1'b0;
      pop_s             = 1'b0;
      if (tx_dv_r && i_Tx_Active) begin
         tx_dv_next_s = 1'b0;
      end else begin
         tx_dv_next_s = tx_dv_r;
      end
      case (state_r)
         IDLE: begin
            if (count_r >= FRAME_C && !i_Tx_Active) begin
               state_next_s   = SYNC;
               tx_dv_next_s   = 1'b1;
               tx_byte_next_s = SYNC_BYTE;
            end else begin
               state_next_s   = IDLE;
            end
         end
         SYNC: begin
            if (advance_s) begin
               state_next_s   = LEN;
               tx_dv_next_s   = 1'b1;
               tx_byte_next_s = LEN_BYTE;
            end else begin
               state_next_s   = SYNC;
            end
         end
         LEN, DATA_LO: begin
            if (advance_s && state_r == DATA_LO && word_cnt_r == LAST_WORD) begin
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
               state_next_s      = CSUM;
               tx_dv_next_s      = 1'b1;
               tx_byte_next_s    = csum_r;
`else
               state_next_s      = IDLE;
               frame_done_next_s = 1'b1;
`endif
            end else if (advance_s) begin
               state_next_s    = DATA_HI;
               pop_s           = 1'b1;
               tx_dv_next_s    = 1'b1;
               tx_byte_next_s  = rd_word_s[15:8];
               lo_byte_next_s  = rd_word_s[7:0];
               word_cnt_next_s = (state_r == LEN) ? 6'd1 : word_cnt_r + 6'd1;
            end else begin
               state_next_s    = state_r;
            end
         end
         DATA_HI: begin
            if (advance_s) begin
               state_next_s   = DATA_LO;
               tx_dv_next_s   = 1'b1;
               tx_byte_next_s = lo_byte_r;
            end else begin
               state_next_s   = DATA_HI;
            end
         end
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
         CSUM: begin
            if (advance_s) begin
               state_next_s      = IDLE;
               frame_done_next_s = 1'b1;
            end else begin
               state_next_s      = CSUM;
            end
         end
`endif
         default: begin
            state_next_s = IDLE;
            tx_dv_next_s = 1'b0;
         end
      endcase
   end

`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
   // Running XOR over LEN and payload bytes as each is loaded for transmission
   always_comb begin
      csum_next_s = csum_r;
      if (state_next_s != state_r) begin
         case (state_next_s)
            LEN:              csum_next_s = tx_byte_next_s;
            DATA_HI, DATA_LO: csum_next_s = csum_update(csum_r, tx_byte_next_s);
            default:          csum_next_s = csum_r;
         endcase
      end else begin
         csum_next_s = csum_r;
      end
   end
`endif

   // Word storage; contents are don't-care until written
   always_ff @(posedge i_Clock) begin
      if (push_s && !i_Reset) begin
         fifo_mem_r[wr_ptr_r] <= i_Word;
      end
   end

   // Control state, FIFO pointers and registered outputs
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         count_r        <= '0;
         ready_r        <= 1'b1;
         overflow_r     <= 1'b0;
         state_r        <= IDLE;
         tx_dv_r        <= 1'b0;
         tx_byte_r      <= 8'h00;
         lo_byte_r      <= 8'h00;
         word_cnt_r     <= 6'd0;
         frame_done_r   <= 1'b0;
         tx_done_prev_r <= i_Tx_Done;
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
         csum_r         <= 8'h00;
`endif
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         if (i_Word_DV && !ready_r) overflow_r <= 1'b1;
         count_r        <= count_next_s;
         ready_r        <= (count_next_s != DEPTH_C);
         state_r        <= state_next_s;
         tx_dv_r        <= tx_dv_next_s;
         tx_byte_r      <= tx_byte_next_s;
         lo_byte_r      <= lo_byte_next_s;
         word_cnt_r     <= word_cnt_next_s;
         frame_done_r   <= frame_done_next_s;
         tx_done_prev_r <= i_Tx_Done;
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
         csum_r         <= csum_next_s;
`endif
      end
   end

   assign o_Word_Ready = ready_r;
   assign o_Overflow   = overflow_r;
   assign o_Tx_DV      = tx_dv_r;
   assign o_Tx_Byte    = tx_byte_r;
   assign o_Frame_Done = frame_done_r;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Self-checking bench for serial_tx_framer: FRAME_WORDS=2 instance with a UART model and byte
// scoreboard, plus a FRAME_WORDS=4 instance for the partial-frame hold-off.
`timescale 1ns/1ps
module tb_serial_tx_framer;

   localparam logic [7:0] SYNC_B = 8'hAA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        w_dv = 1'b0;
   logic [15:0] w_data = 16'h0000;
   logic        w_ready, tx_dv, frame_done, overflow;
   logic [7:0]  tx_byte;
   logic        tx_active = 1'b0, tx_done = 1'b0;

   logic        w4_dv = 1'b0;
   logic [15:0] w4_data = 16'h0000;
   logic        w4_ready, tx4_dv, frame4_done, overflow4;
   logic [7:0]  tx4_byte;
   logic        tx4_active = 1'b0, tx4_done = 1'b0;

   serial_tx_framer #(.FRAME_WORDS(2), .FIFO_DEPTH(16), .SYNC_BYTE(8'hAA)) dut (
      .i_Clock(clk), .i_Reset(rst), .i_Word_DV(w_dv), .i_Word(w_data), .o_Word_Ready(w_ready),
      .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
      .o_Frame_Done(frame_done), .o_Overflow(overflow));

   serial_tx_framer #(.FRAME_WORDS(4), .FIFO_DEPTH(16), .SYNC_BYTE(8'hAA)) dut4 (
      .i_Clock(clk), .i_Reset(rst), .i_Word_DV(w4_dv), .i_Word(w4_data), .o_Word_Ready(w4_ready),
      .o_Tx_DV(tx4_dv), .o_Tx_Byte(tx4_byte), .i_Tx_Active(tx4_active), .i_Tx_Done(tx4_done),
      .o_Frame_Done(frame4_done), .o_Overflow(overflow4));

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   bit         last_q[$];
   int         frames_exp = 0, frames_seen = 0, accepted = 0;
   int         busy_cnt = 0, done_cnt = 0, done_hold = 1;
   bit         stall = 1'b0, cur_last = 1'b0;
   logic       prev_dv = 1'b0, prev_fd = 1'b0;
   logic [7:0] prev_byte = 8'h00;

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  csum;
      int          hold;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_csum(input logic [15:0] a, input logic [15:0] b);
      return 8'h04 ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0];
   endfunction

   task automatic expect_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] cs);
      exp_q.push_back(SYNC_B);  last_q.push_back(1'b0);
      exp_q.push_back(8'h04);   last_q.push_back(1'b0);
      exp_q.push_back(a[15:8]); last_q.push_back(1'b0);
      exp_q.push_back(a[7:0]);  last_q.push_back(1'b0);
      exp_q.push_back(b[15:8]); last_q.push_back(1'b0);
`ifdef SERIAL_TX_FRAMER_CHECKSUM_EN
      exp_q.push_back(b[7:0]);  last_q.push_back(1'b0);
      exp_q.push_back(cs);      last_q.push_back(1'b1);
`else
      exp_q.push_back(b[7:0]);  last_q.push_back(1'b1);
      if (cs === 8'hxx) $display("note: checksum byte not sent in this build");
`endif
      frames_exp++;
   endtask

   task automatic push_word(input logic [15:0] w);
      w_dv = 1'b1; w_data = w;
      @(negedge clk);
      w_dv = 1'b0;
   endtask

   task automatic push4(input logic [15:0] w);
      w4_dv = 1'b1; w4_data = w;
      @(negedge clk);
      w4_dv = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || tx_active || tx_done || frames_seen != frames_exp) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_in_time"}, n < 3000, 1'b1);
      repeat (3) @(negedge clk);
      check({name, "_frames"}, frames_seen, frames_exp);
   endtask

   // UART transmitter model and output scoreboard, stepping on the falling edge
   always @(negedge clk) begin
      logic [7:0] e;
      if (tx_dv && prev_dv) check("byte_stable_while_dv", tx_byte, prev_byte);
      if (frame_done) begin
         check("frame_done_one_cycle", prev_fd, 1'b0);
         check("frame_done_after_last_byte", cur_last, 1'b1);
         frames_seen++;
      end
      prev_fd = frame_done; prev_dv = tx_dv; prev_byte = tx_byte;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) tx_done = 1'b0;
      end
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            tx_active = 1'b0; tx_done = 1'b1; done_cnt = done_hold;
         end
      end else if (tx_dv && !tx_active && !stall) begin
         accepted++;
         tx_active = 1'b1; busy_cnt = 3;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte: got %02h expected none", tx_byte);
         end else begin
            e = exp_q.pop_front();
            cur_last = last_q.pop_front();
            check("tx_byte", tx_byte, e);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int n;
      int base;
      logic [15:0] a, b;
      vecs[0] = '{16'h1234, 16'hABCD, 8'h44, 1};
      vecs[1] = '{16'hDEAD, 16'hBEEF, 8'h26, 2};
      vecs[2] = '{16'h0102, 16'h0304, 8'h00, 2};
      vecs[3] = '{16'h8000, 16'h0001, 8'h85, 1};
      vecs[4] = '{16'hFFFF, 16'h0000, 8'h04, 2};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx_dv", tx_dv, 1'b0);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_ready", w_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // Partial frame must not start; completing it starts SYNC promptly
      for (int i = 0; i < 3; i++) push4(16'h1000 + 16'(i));
      repeat (6) begin
         check("fw4_no_partial_start", tx4_dv, 1'b0);
         @(negedge clk);
      end
      push4(16'h1003);
      n = 0;
      while (!tx4_dv && n < 2) begin @(negedge clk); n++; end
      check("fw4_sync_within_2", tx4_dv, 1'b1);
      check("fw4_sync_byte", tx4_byte, SYNC_B);
      repeat (4) @(negedge clk);
      check("fw4_dv_held", tx4_dv, 1'b1);
      check("fw4_byte_held", tx4_byte, SYNC_B);

      // Table of single frames, Done held one or two cycles
      for (int i = 0; i < 5; i++) begin
         done_hold = vecs[i].hold;
         expect_frame(vecs[i].w0, vecs[i].w1, vecs[i].csum);
         push_word(vecs[i].w0);
         push_word(vecs[i].w1);
         wait_drain("vec");
      end

      // Back-to-back frames: next SYNC follows the Frame_Done cycle
      done_hold = 1;
      expect_frame(16'h1111, 16'h2222, frame_csum(16'h1111, 16'h2222));
      expect_frame(16'h3333, 16'h4444, frame_csum(16'h3333, 16'h4444));
      push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
      n = 0;
      while (!frame_done && n < 500) begin @(negedge clk); n++; end
      check("b2b_first_done_seen", frame_done, 1'b1);
      @(negedge clk);
      check("b2b_next_sync_dv", tx_dv, 1'b1);
      check("b2b_next_sync_byte", tx_byte, SYNC_B);
      wait_drain("b2b");

      // Overflow with stalled transmitter
      stall = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_ready_before_push", w_ready, 1'b1);
         b = 16'h3000 + 16'(i * 257);
         if (i % 2 == 1) expect_frame(a, b, frame_csum(a, b));
         a = b;
         push_word(b);
      end
      check("ovf_ready_full", w_ready, 1'b0);
      check("ovf_flag_clear_at_full", overflow, 1'b0);
      push_word(16'hDEAD);
      check("ovf_flag_set", overflow, 1'b1);
      check("ovf_still_full", w_ready, 1'b0);
      stall = 1'b0;
      wait_drain("ovf");
      check("ovf_sticky", overflow, 1'b1);
      expect_frame(16'h5555, 16'h6666, frame_csum(16'h5555, 16'h6666));
      push_word(16'h5555); push_word(16'h6666);
      wait_drain("ovf_dropped_word_absent");

      // Reset while the DATA_HI byte is on the wire
      expect_frame(16'hC0DE, 16'hF00D, 8'h00);
      base = accepted;
      push_word(16'hC0DE); push_word(16'hF00D);
      n = 0;
      while (accepted < base + 3 && n < 300) begin @(negedge clk); n++; end
      check("rst_mid_reached_data_hi", accepted, base + 3);
      rst = 1'b1; w_dv = 1'b1; w_data = 16'h7777;
      @(negedge clk);
      rst = 1'b0; w_dv = 1'b0;
      exp_q.delete(); last_q.delete(); frames_exp--;
      check("rst_mid_tx_dv", tx_dv, 1'b0);
      check("rst_mid_ready", w_ready, 1'b1);
      check("rst_mid_byte", tx_byte, 8'h00);
      check("rst_mid_overflow_cleared", overflow, 1'b0);
      push_word(16'h2468);
      n = 0;
      while (tx_active && n < 50) begin
         check("rst_no_dv_while_active", tx_dv, 1'b0);
         @(negedge clk); n++;
      end
      repeat (5) begin
         check("rst_fifo_empty_no_start", tx_dv, 1'b0);
         @(negedge clk);
      end
      expect_frame(16'h2468, 16'h1357, frame_csum(16'h2468, 16'h1357));
      push_word(16'h1357);
      wait_drain("rst_restart");

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
